// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner, stepped by the slow scan clock.
// Emits a one-cycle key event with row*4+col code, plus a held flag.
module keypad_scanner #(
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_clk,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HOLD
    } state_t;

    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    state_t     state;
    logic       kc_s1;
    logic       kc_s2;
    logic       kc_s3;
    logic       tick;
    logic [3:0] col_s1;
    logic [3:0] col_s2;
    logic [1:0] row_idx;
    logic [1:0] cap_col;
    logic [3:0] cnt;
    logic [3:0] cnt_inc;
    logic       key_any;
    logic [1:0] col_dec;
    logic [1:0] row_nxt;

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Lowest-numbered low column wins when several keys share a row.
    always_comb begin
        key_any = ~&col_s2;
        col_dec = 2'd0;
        if (!col_s2[0])
            col_dec = 2'd0;
        else if (!col_s2[1])
            col_dec = 2'd1;
        else if (!col_s2[2])
            col_dec = 2'd2;
        else if (!col_s2[3])
            col_dec = 2'd3;
    end

    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    assign row_nxt = row_idx + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kc_s1  <= 1'b0;
            kc_s2  <= 1'b0;
            kc_s3  <= 1'b0;
            tick   <= 1'b0;
            col_s1 <= 4'hF;
            col_s2 <= 4'hF;
        end else begin
            kc_s1  <= key_clk;
            kc_s2  <= kc_s1;
            kc_s3  <= kc_s2;
            tick   <= kc_s2 & ~kc_s3;
            col_s1 <= col_in;
            col_s2 <= col_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            row_out   <= 4'b1110;
            cap_col   <= 2'd0;
            cnt       <= 4'd0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                unique case (state)
                    SCAN: begin
                        if (key_any) begin
                            cap_col <= col_dec;
                            if (DEB <= 4'd1) begin
                                key_code  <= {row_idx, col_dec};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= 4'd0;
                                state     <= HOLD;
                            end else begin
                                cnt   <= 4'd1;
                                state <= DEBOUNCE;
                            end
                        end else begin
                            row_idx <= row_nxt;
                            row_out <= row_drive(row_nxt);
                        end
                    end
                    DEBOUNCE: begin
                        if (key_any && col_dec == cap_col) begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= DEB) begin
                                key_code  <= {row_idx, cap_col};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= 4'd0;
                                state     <= HOLD;
                            end
                        end else begin
                            cnt     <= 4'd0;
                            state   <= SCAN;
                            row_idx <= row_nxt;
                            row_out <= row_drive(row_nxt);
                        end
                    end
                    HOLD: begin
                        // Any low column restarts the release count.
                        if (!key_any) begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= DEB) begin
                                key_held <= 1'b0;
                                cnt      <= 4'd0;
                                state    <= SCAN;
                                row_idx  <= row_nxt;
                                row_out  <= row_drive(row_nxt);
                            end
                        end else begin
                            cnt <= 4'd0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule
